// File: rtl/pwm_seq_pkg.sv
// Shared types and constants for the PWM profile sequencer and its profile table.
package pwm_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLdMax,
    StLdDuty,
    StLdStop,
    StStart,
    StWait,
    StNext
  } seq_state_e;

  typedef struct packed {
    logic [15:0] max_cnt;
    logic [15:0] duty_cnt;
    logic [15:0] stop_cnt;
  } pwm_entry_t;

  localparam logic [1:0] SEL_MAX  = 2'd0;
  localparam logic [1:0] SEL_DUTY = 2'd1;
  localparam logic [1:0] SEL_STOP = 2'd2;

  localparam logic [1:0] TADDR_MAX  = 2'd0;
  localparam logic [1:0] TADDR_PWM  = 2'd1;
  localparam logic [1:0] TADDR_STOP = 2'd2;

endpackage

// File: rtl/pwm_seq_table.sv
// Profile register file: one host write port, one async read port for playback.
// Host writes are only accepted while the sequencer is idle.
module pwm_seq_table
  import pwm_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_idle,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [1:0]       i_sel,
  input  logic [15:0]      i_wdata,
  input  logic [IDX_W-1:0] i_ridx,
  output logic [47:0]      o_rdata,
  output logic             o_cfg_err
);

  pwm_entry_t tbl_q [DEPTH];
  logic       commit;

  assign commit  = i_we && i_idle && (i_sel != 2'd3);
  assign o_rdata = tbl_q[i_ridx];

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tbl_q[i] <= '0;
      end
      o_cfg_err <= 1'b0;
    end else begin
      o_cfg_err <= i_we && !commit;
      if (commit) begin
        unique case (i_sel)
          SEL_MAX:  tbl_q[i_idx].max_cnt  <= i_wdata;
          SEL_DUTY: tbl_q[i_idx].duty_cnt <= i_wdata;
          SEL_STOP: tbl_q[i_idx].stop_cnt <= i_wdata;
          default:  ;
        endcase
      end
    end
  end

endmodule

// File: rtl/pwm_timer_sequencer.sv
// Plays a table of PWM profiles onto a timer: program max/duty/stop, start, wait for end, advance.
// Timer-side outputs are decoded from the state register and the table, never from inputs.
module pwm_timer_sequencer
  import pwm_seq_pkg::*;
#(
  parameter int unsigned     DEPTH   = 4,
  parameter int unsigned     IDX_W   = 2,
  parameter int unsigned     TO_W    = 24,
  parameter logic [TO_W-1:0] TIMEOUT = 24'hFFFFFF
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_cfg_we,
  input  logic [IDX_W-1:0] i_cfg_idx,
  input  logic [1:0]       i_cfg_sel,
  input  logic [15:0]      i_cfg_wdata,
  input  logic [IDX_W-1:0] i_last_idx,
  input  logic             i_run,
  input  logic             i_loop,
  input  logic             i_abort,
  input  logic             i_tmr_end,
  output logic             o_tmr_we,
  output logic [1:0]       o_tmr_addr,
  output logic [15:0]      o_tmr_wdata,
  output logic             o_tmr_start,
  output logic             o_busy,
  output logic [IDX_W-1:0] o_step_idx,
  output logic             o_seq_done,
  output logic             o_timeout,
  output logic             o_cfg_err
);

  localparam logic [TO_W-1:0] WdLast = TIMEOUT - 1'b1;

  seq_state_e       state_q;
  logic [IDX_W-1:0] idx_q;
  logic [TO_W-1:0]  wd_q;
  logic             end_q;
  logic             end_rise;
  logic [47:0]      rd_raw;
  pwm_entry_t       rd;

  pwm_seq_table #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_table (
    .i_clk     (i_clk),
    .i_rstn    (i_rstn),
    .i_idle    (state_q == StIdle),
    .i_we      (i_cfg_we),
    .i_idx     (i_cfg_idx),
    .i_sel     (i_cfg_sel),
    .i_wdata   (i_cfg_wdata),
    .i_ridx    (idx_q),
    .o_rdata   (rd_raw),
    .o_cfg_err (o_cfg_err)
  );

  assign rd       = pwm_entry_t'(rd_raw);
  assign end_rise = i_tmr_end && !end_q;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      wd_q       <= '0;
      end_q      <= 1'b0;
      o_timeout  <= 1'b0;
      o_seq_done <= 1'b0;
    end else begin
      end_q      <= i_tmr_end;
      o_seq_done <= 1'b0;
      if ((state_q != StIdle) && i_abort) begin
        state_q <= StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (i_run) begin
              idx_q     <= '0;
              o_timeout <= 1'b0;
              state_q   <= StLdMax;
            end
          end
          // A zero stop count marks an unused entry: no writes, no start.
          StLdMax:  state_q <= (rd.stop_cnt == '0) ? StNext : StLdDuty;
          StLdDuty: state_q <= StLdStop;
          StLdStop: state_q <= StStart;
          StStart: begin
            wd_q    <= '0;
            state_q <= StWait;
          end
          StWait: begin
            if (end_rise) begin
              state_q <= StNext;
            end else if (wd_q == WdLast) begin
              o_timeout <= 1'b1;
              state_q   <= StIdle;
            end else begin
              wd_q <= wd_q + 1'b1;
            end
          end
          StNext: begin
            if (idx_q != i_last_idx) begin
              idx_q   <= idx_q + 1'b1;
              state_q <= StLdMax;
            end else if (i_loop) begin
              idx_q   <= '0;
              state_q <= StLdMax;
            end else begin
              o_seq_done <= 1'b1;
              state_q    <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  always_comb begin
    o_tmr_we    = 1'b0;
    o_tmr_addr  = TADDR_MAX;
    o_tmr_wdata = '0;
    o_tmr_start = 1'b0;
    unique case (state_q)
      StLdMax: begin
        if (rd.stop_cnt != '0) begin
          o_tmr_we    = 1'b1;
          o_tmr_addr  = TADDR_MAX;
          o_tmr_wdata = rd.max_cnt;
        end
      end
      StLdDuty: begin
        o_tmr_we    = 1'b1;
        o_tmr_addr  = TADDR_PWM;
        o_tmr_wdata = rd.duty_cnt;
      end
      StLdStop: begin
        o_tmr_we    = 1'b1;
        o_tmr_addr  = TADDR_STOP;
        o_tmr_wdata = rd.stop_cnt;
      end
      StStart: o_tmr_start = 1'b1;
      default: ;
    endcase
  end

  assign o_busy     = (state_q != StIdle);
  assign o_step_idx = idx_q;

endmodule

// File: tb/tb_pwm_timer_sequencer.sv
// Self-checking bench: timer-port writes/starts are matched against a scoreboard queue.
module tb_pwm_timer_sequencer;

  logic        clk = 1'b0;
  logic        rstn, cfg_we, run, loop_en, abort, tmr_end;
  logic [1:0]  cfg_idx, cfg_sel, last_idx;
  logic [15:0] cfg_wdata;
  logic        tmr_we, tmr_start, busy, seq_done, timeout, cfg_err;
  logic [1:0]  tmr_addr, step_idx;
  logic [15:0] tmr_wdata;

  int          vectors = 0;
  int          miscompares = 0;
  int          done_cnt = 0;
  logic        saw_start = 1'b0;
  logic [18:0] exp_q [$];

  always #5 clk = ~clk;

  pwm_timer_sequencer #(
    .DEPTH   (4),
    .IDX_W   (2),
    .TO_W    (24),
    .TIMEOUT (24'd16)
  ) dut (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .i_cfg_we    (cfg_we),
    .i_cfg_idx   (cfg_idx),
    .i_cfg_sel   (cfg_sel),
    .i_cfg_wdata (cfg_wdata),
    .i_last_idx  (last_idx),
    .i_run       (run),
    .i_loop      (loop_en),
    .i_abort     (abort),
    .i_tmr_end   (tmr_end),
    .o_tmr_we    (tmr_we),
    .o_tmr_addr  (tmr_addr),
    .o_tmr_wdata (tmr_wdata),
    .o_tmr_start (tmr_start),
    .o_busy      (busy),
    .o_step_idx  (step_idx),
    .o_seq_done  (seq_done),
    .o_timeout   (timeout),
    .o_cfg_err   (cfg_err)
  );

  // One clock; samples 1 time unit after the edge and scores any timer-port activity.
  task automatic tick();
    logic [18:0] obs, exp;
    @(posedge clk);
    #1;
    if (seq_done) done_cnt++;
    if (tmr_start) saw_start = 1'b1;
    if (tmr_we || tmr_start) begin
      obs = {tmr_start, tmr_addr, tmr_wdata};
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL tmr_event: got %h, required no event", obs);
      end else begin
        exp = exp_q.pop_front();
        if (obs !== exp) begin
          miscompares++;
          $display("FAIL tmr_event: got %h, required %h", obs, exp);
        end
      end
    end
  endtask

  task automatic push_entry(input logic [15:0] mx, input logic [15:0] dt, input logic [15:0] st);
    exp_q.push_back({1'b0, 2'd0, mx});
    exp_q.push_back({1'b0, 2'd1, dt});
    exp_q.push_back({1'b0, 2'd2, st});
    exp_q.push_back({1'b1, 2'd0, 16'h0000});
  endtask

  task automatic cfg_write(input logic [1:0] idx, input logic [1:0] sel, input logic [15:0] data);
    cfg_we = 1'b1; cfg_idx = idx; cfg_sel = sel; cfg_wdata = data;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic program_entry(input logic [1:0] idx, input logic [15:0] mx,
                               input logic [15:0] dt, input logic [15:0] st);
    cfg_write(idx, 2'd0, mx);
    cfg_write(idx, 2'd1, dt);
    cfg_write(idx, 2'd2, st);
  endtask

  task automatic pulse_run();
    run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  task automatic pulse_end();
    tmr_end = 1'b1;
    tick();
    tmr_end = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    saw_start = 1'b0;
    while (!saw_start && n < 40) begin
      tick();
      n++;
    end
    vectors++;
    if (!saw_start) begin
      miscompares++;
      $display("FAIL %s_start: got no start in 40 cycles, required start", tag);
    end
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && n < 40) begin
      tick();
      n++;
    end
    vectors++;
    if (done_cnt != d0 + 1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_done: got done=%0d busy=%b, required done=1 busy=0", tag,
               done_cnt - d0, busy);
    end
  endtask

  task automatic check_drained(input string tag);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_drain: got %0d pending events, required 0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_sel = '0; cfg_wdata = '0;
    last_idx = '0; run = 1'b0; loop_en = 1'b0; abort = 1'b0; tmr_end = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    vectors++;
    if ({tmr_we, tmr_start, busy, step_idx, seq_done, timeout, cfg_err} !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b, required 00000000",
               {tmr_we, tmr_start, busy, step_idx, seq_done, timeout, cfg_err});
    end
  endtask

  task automatic test_basic();
    program_entry(2'd0, 16'd100, 16'd40, 16'd3);
    program_entry(2'd1, 16'd200, 16'd50, 16'd2);
    last_idx = 2'd1; loop_en = 1'b0;
    push_entry(16'd100, 16'd40, 16'd3);
    push_entry(16'd200, 16'd50, 16'd2);
    pulse_run();
    vectors++;
    if (busy !== 1'b1 || tmr_we !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_run_latency: got busy=%b we=%b, required 1 1", busy, tmr_we);
    end
    wait_start("basic0");
    tick();
    pulse_end();
    tick();
    vectors++;
    if (tmr_we !== 1'b1 || step_idx !== 2'd1) begin
      miscompares++;
      $display("FAIL basic_end_latency: got we=%b idx=%0d, required we=1 idx=1", tmr_we, step_idx);
    end
    wait_start("basic1");
    tick();
    pulse_end();
    wait_done("basic");
    check_drained("basic");
  endtask

  task automatic test_hold_end();
    int d0 = done_cnt;
    push_entry(16'd100, 16'd40, 16'd3);
    push_entry(16'd200, 16'd50, 16'd2);
    pulse_run();
    wait_start("hold");
    tick();
    tmr_end = 1'b1;
    repeat (10) tick();
    tmr_end = 1'b0;
    tick();
    vectors++;
    if (exp_q.size() != 0 || busy !== 1'b1 || step_idx !== 2'd1 || done_cnt != d0) begin
      miscompares++;
      $display("FAIL hold_single_advance: got pend=%0d busy=%b idx=%0d done=%0d, required 0 1 1 0",
               exp_q.size(), busy, step_idx, done_cnt - d0);
    end
    tick();
    pulse_end();
    wait_done("hold");
  endtask

  task automatic test_skip();
    program_entry(2'd0, 16'd11, 16'd1, 16'd1);
    program_entry(2'd1, 16'd22, 16'd2, 16'd0);
    program_entry(2'd2, 16'd33, 16'd3, 16'd3);
    last_idx = 2'd2;
    push_entry(16'd11, 16'd1, 16'd1);
    push_entry(16'd33, 16'd3, 16'd3);
    pulse_run();
    wait_start("skip0");
    tick();
    pulse_end();
    tick();
    tick();
    tick();
    vectors++;
    if (tmr_we !== 1'b1 || step_idx !== 2'd2) begin
      miscompares++;
      $display("FAIL skip_entry2: got we=%b idx=%0d, required we=1 idx=2", tmr_we, step_idx);
    end
    wait_start("skip2");
    tick();
    pulse_end();
    wait_done("skip");
    check_drained("skip");
  endtask

  task automatic test_loop_abort();
    int d0;
    program_entry(2'd1, 16'd44, 16'd4, 16'd4);
    last_idx = 2'd1; loop_en = 1'b1;
    push_entry(16'd11, 16'd1, 16'd1);
    push_entry(16'd44, 16'd4, 16'd4);
    push_entry(16'd11, 16'd1, 16'd1);
    pulse_run();
    wait_start("loop0");
    tick();
    pulse_end();
    wait_start("loop1");
    tick();
    pulse_end();
    tick();
    vectors++;
    if (tmr_we !== 1'b1 || step_idx !== 2'd0) begin
      miscompares++;
      $display("FAIL loop_restart: got we=%b idx=%0d, required we=1 idx=0", tmr_we, step_idx);
    end
    wait_start("loop2");
    tick();
    d0 = done_cnt;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    loop_en = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_idle: got busy=%b, required 0", busy);
    end
    repeat (3) tick();
    vectors++;
    if (done_cnt != d0) begin
      miscompares++;
      $display("FAIL abort_no_done: got %0d done pulses, required 0", done_cnt - d0);
    end
    check_drained("loop");
  endtask

  task automatic test_timeout();
    int d0 = done_cnt;
    last_idx = 2'd0;
    push_entry(16'd11, 16'd1, 16'd1);
    pulse_run();
    wait_start("wd");
    repeat (16) tick();
    vectors++;
    if (timeout !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL wd_early: got timeout=%b busy=%b, required 0 1", timeout, busy);
    end
    tick();
    vectors++;
    if (timeout !== 1'b1 || busy !== 1'b0 || done_cnt != d0) begin
      miscompares++;
      $display("FAIL wd_expire: got timeout=%b busy=%b done=%0d, required 1 0 0",
               timeout, busy, done_cnt - d0);
    end
    exp_q.push_back({1'b0, 2'd0, 16'd11});
    pulse_run();
    vectors++;
    if (timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL wd_clear: got timeout=%b, required 0", timeout);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_drained("wd");
  endtask

  task automatic test_cfg_err();
    cfg_write(2'd0, 2'd3, 16'hBEEF);
    vectors++;
    if (cfg_err !== 1'b1) begin
      miscompares++;
      $display("FAIL cfg_err_sel3: got %b, required 1", cfg_err);
    end
    tick();
    vectors++;
    if (cfg_err !== 1'b0) begin
      miscompares++;
      $display("FAIL cfg_err_pulse: got %b, required 0", cfg_err);
    end
    push_entry(16'd11, 16'd1, 16'd1);
    pulse_run();
    cfg_write(2'd0, 2'd0, 16'd999);
    vectors++;
    if (cfg_err !== 1'b1) begin
      miscompares++;
      $display("FAIL cfg_err_busy: got %b, required 1", cfg_err);
    end
    wait_start("cfg0");
    tick();
    pulse_end();
    wait_done("cfg0");
    push_entry(16'd11, 16'd1, 16'd1);
    pulse_run();
    wait_start("cfg1");
    tick();
    pulse_end();
    wait_done("cfg1");
    check_drained("cfg");
  endtask

  task automatic test_reset_mid();
    exp_q.push_back({1'b0, 2'd0, 16'd11});
    exp_q.push_back({1'b0, 2'd1, 16'd1});
    pulse_run();
    tick();
    rstn = 1'b0;
    tick();
    vectors++;
    if ({tmr_we, tmr_start, busy, step_idx, seq_done, timeout, cfg_err, tmr_addr, tmr_wdata}
        !== 26'h0) begin
      miscompares++;
      $display("FAIL rst_mid_outputs: got we=%b st=%b busy=%b idx=%0d addr=%0d data=%0d, required 0",
               tmr_we, tmr_start, busy, step_idx, tmr_addr, tmr_wdata);
    end
    rstn = 1'b1;
    check_drained("rst_mid");
    last_idx = 2'd0;
    pulse_run();
    wait_done("rst_zero_table");
    check_drained("rst_zero_table");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold_end();
    test_skip();
    test_loop_abort();
    test_timeout();
    test_cfg_err();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
